// File: rtl/id_decode_stage_pkg.sv
// Shared constants and types for the ID stage.
//   - opcode / funct / regimm-rt encodings of the decoded MIPS subset
//   - bus widths (ID_TO_EX_WD, BR_WD, FWD_WD, WB_WD)
//   - alu_op one-hot bit indices and ALU source-select codes
//   - forwarding entry layout and an R-type funct -> alu_op helper
package id_decode_stage_pkg;

   localparam int ID_TO_EX_WD = 159;
   localparam int BR_WD       = 33;
   localparam int FWD_WD      = 39;
   localparam int WB_WD       = 38;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;

   localparam logic [4:0] RT_BLTZ   = 5'h00;
   localparam logic [4:0] RT_BGEZ   = 5'h01;
   localparam logic [4:0] RT_BLTZAL = 5'h10;
   localparam logic [4:0] RT_BGEZAL = 5'h11;

   // alu_op is one-hot; bit 11 is add, bit 0 is lui
   localparam int ALU_ADD  = 11;
   localparam int ALU_SUB  = 10;
   localparam int ALU_SLT  = 9;
   localparam int ALU_SLTU = 8;
   localparam int ALU_AND  = 7;
   localparam int ALU_NOR  = 6;
   localparam int ALU_OR   = 5;
   localparam int ALU_XOR  = 4;
   localparam int ALU_SLL  = 3;
   localparam int ALU_SRL  = 2;
   localparam int ALU_SRA  = 1;
   localparam int ALU_LUI  = 0;

   localparam logic [2:0] SRC1_RS   = 3'b001;
   localparam logic [2:0] SRC1_PC   = 3'b010;
   localparam logic [2:0] SRC1_SA   = 3'b100;
   localparam logic [3:0] SRC2_RT   = 4'b0001;
   localparam logic [3:0] SRC2_SIMM = 4'b0010;
   localparam logic [3:0] SRC2_C8   = 4'b0100;
   localparam logic [3:0] SRC2_ZIMM = 4'b1000;

   typedef struct packed {
      logic        is_load;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } fwd_entry_t;

   function automatic logic [11:0] alu_op_of_funct(input logic [5:0] funct);
      logic [11:0] op;
      op = '0;
      case (funct)
         FN_ADDU: op[ALU_ADD]  = 1'b1;
         FN_SUBU: op[ALU_SUB]  = 1'b1;
         FN_AND:  op[ALU_AND]  = 1'b1;
         FN_OR:   op[ALU_OR]   = 1'b1;
         FN_XOR:  op[ALU_XOR]  = 1'b1;
         FN_NOR:  op[ALU_NOR]  = 1'b1;
         FN_SLT:  op[ALU_SLT]  = 1'b1;
         FN_SLTU: op[ALU_SLTU] = 1'b1;
         FN_SLL:  op[ALU_SLL]  = 1'b1;
         FN_SRL:  op[ALU_SRL]  = 1'b1;
         FN_SRA:  op[ALU_SRA]  = 1'b1;
         default: op = '0;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/id_decode_stage_inst_buf.sv
// id_inst_buf: holds the synchronous-SRAM instruction word across ID stalls.
//   clk, rst        clock, synchronous active-high reset
//   flush           drops any held word
//   stall_id        1 = ID stage stopped
//   inst_sram_rdata SRAM read data (valid the cycle after the IF request)
//   inst            instruction seen by the decoder
//   hold_v          1 = inst comes from the hold register
module id_inst_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        stall_id,
   input  logic [31:0] inst_sram_rdata,
   output logic [31:0] inst,
   output logic        hold_v
);

   logic [31:0] hold_inst;

   // Capture only on the first stalled cycle: later SRAM data belongs to
   // whatever IF requested next, not to the instruction sitting in ID.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         hold_v    <= 1'b0;
         hold_inst <= '0;
      end else if (stall_id) begin
         if (!hold_v) begin
            hold_v    <= 1'b1;
            hold_inst <= inst_sram_rdata;
         end
      end else begin
         hold_v <= 1'b0;
      end
   end

   assign inst = hold_v ? hold_inst : inst_sram_rdata;

endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: MIPS ID stage between IF and EX.
// Registers {ce, pc} from IF, decodes the integer / load-store / branch
// subset, forwards rs/rt from NFWD later stages (index 0 = highest
// priority), raises the load-use interlock and resolves branches.
// Optional feature macro: ID_BRANCH_EXT_EN adds bgez/bgtz/blez/bltz,
// bgezal/bltzal and jalr; without it those encodings decode as NOP.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall[5:0]        bit 1 = ID stop, bit 2 = EX stop
//   flush             clears the ID register and the instruction hold
//   if_to_id_bus      {ce, pc}
//   inst_sram_rdata   instruction word
//   fwd_bus           NFWD x {is_load, we, waddr, wdata}, entry 0 in LSBs
//   wb_to_rf_bus      {we, waddr, wdata} register-file write port
//   stallreq          load-use interlock request (combinational)
//   id_to_ex_bus      {pc, inst, alu_op, src1, src2, ram_en, ram_wen,
//                      rf_we, rf_waddr, sel_rf_res, rdata1, rdata2}
//   br_bus            {br_e, br_addr}
module id_decode_stage #(
   parameter int NFWD   = 3,
   parameter int FWD_WD = id_decode_stage_pkg::FWD_WD
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [5:0]                            stall,
   input  logic                                  flush,
   input  logic [32:0]                           if_to_id_bus,
   input  logic [31:0]                           inst_sram_rdata,
   input  logic [NFWD*FWD_WD-1:0]                fwd_bus,
   input  logic [id_decode_stage_pkg::WB_WD-1:0] wb_to_rf_bus,
   output logic                                  stallreq,
   output logic [id_decode_stage_pkg::ID_TO_EX_WD-1:0] id_to_ex_bus,
   output logic [id_decode_stage_pkg::BR_WD-1:0]       br_bus
);

   import id_decode_stage_pkg::*;

   logic        id_ce;
   logic [31:0] id_pc;
   logic [31:0] inst_raw, inst_d;
   logic        hold_v;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         id_ce <= 1'b0;
         id_pc <= '0;
      end else if (stall[1] && !stall[2]) begin
         id_ce <= 1'b0;
         id_pc <= '0;
      end else if (!stall[1]) begin
         id_ce <= if_to_id_bus[32];
         id_pc <= if_to_id_bus[31:0];
      end
   end

   id_inst_buf u_inst_buf (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .stall_id        (stall[1]),
      .inst_sram_rdata (inst_sram_rdata),
      .inst            (inst_raw),
      .hold_v          (hold_v)
   );

   assign inst_d = id_ce ? inst_raw : '0;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   assign op    = inst_d[31:26];
   assign rs    = inst_d[25:21];
   assign rt    = inst_d[20:16];
   assign rd    = inst_d[15:11];
   assign imm   = inst_d[15:0];
   assign funct = inst_d[5:0];

   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   assign {wb_we, wb_waddr, wb_wdata} = wb_to_rf_bus;

   logic [31:0] rf [32];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wb_we && wb_waddr != 5'd0) begin
         rf[wb_waddr] <= wb_wdata;
      end
   end

   fwd_entry_t fwd [NFWD];
   for (genvar g = 0; g < NFWD; g++) begin : g_fwd
      assign fwd[g] = fwd_bus[g*FWD_WD +: $bits(fwd_entry_t)];
   end

   // Priority, lowest first: regfile, WB bypass, then fwd entries from the
   // highest index down so entry 0 has the final say.
   logic [31:0] rdata1, rdata2;
   always_comb begin
      rdata1 = (wb_we && wb_waddr == rs) ? wb_wdata : rf[rs];
      rdata2 = (wb_we && wb_waddr == rt) ? wb_wdata : rf[rt];
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (fwd[i].we && fwd[i].waddr == rs) rdata1 = fwd[i].wdata;
         if (fwd[i].we && fwd[i].waddr == rt) rdata2 = fwd[i].wdata;
      end
      if (rs == 5'd0) rdata1 = '0;
      if (rt == 5'd0) rdata2 = '0;
   end

   logic [31:0] pc_plus_4, br_rel, j_abs;
   assign pc_plus_4 = id_pc + 32'd4;
   assign br_rel    = pc_plus_4 + {{14{imm[15]}}, imm, 2'b00};
   assign j_abs     = {pc_plus_4[31:28], inst_d[25:0], 2'b00};

   logic [11:0] alu_op;
   logic [2:0]  src1;
   logic [3:0]  src2;
   logic        ram_en, rf_we, sel_rf_res, rs_used, rt_used, br_take;
   logic [3:0]  ram_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] br_tgt;

   // Decoding only happens with ce=1, so every enable is qualified by ce.
   always_comb begin
      alu_op     = '0;
      src1       = '0;
      src2       = '0;
      ram_en     = 1'b0;
      ram_wen    = '0;
      rf_we      = 1'b0;
      rf_waddr   = '0;
      sel_rf_res = 1'b0;
      rs_used    = 1'b0;
      rt_used    = 1'b0;
      br_take    = 1'b0;
      br_tgt     = '0;
      if (id_ce) begin
         case (op)
            OP_SPECIAL: begin
               case (funct)
                  FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                     alu_op = alu_op_of_funct(funct);
                     src1 = SRC1_RS; src2 = SRC2_RT;
                     rs_used = 1'b1; rt_used = 1'b1;
                     rf_we = 1'b1; rf_waddr = rd;
                  end
                  FN_SLL, FN_SRL, FN_SRA: begin
                     alu_op = alu_op_of_funct(funct);
                     src1 = SRC1_SA; src2 = SRC2_RT;
                     rt_used = 1'b1;
                     rf_we = 1'b1; rf_waddr = rd;
                  end
                  FN_JR: begin
                     rs_used = 1'b1; br_take = 1'b1; br_tgt = rdata1;
                  end
`ifdef ID_BRANCH_EXT_EN
                  FN_JALR: begin
                     rs_used = 1'b1; br_take = 1'b1; br_tgt = rdata1;
                     alu_op[ALU_ADD] = 1'b1; src1 = SRC1_PC; src2 = SRC2_C8;
                     rf_we = 1'b1; rf_waddr = rd;
                  end
`endif
                  default: ;
               endcase
            end
            OP_ADDIU: begin
               alu_op[ALU_ADD] = 1'b1; src1 = SRC1_RS; src2 = SRC2_SIMM;
               rs_used = 1'b1; rf_we = 1'b1; rf_waddr = rt;
            end
            OP_ORI: begin
               alu_op[ALU_OR] = 1'b1; src1 = SRC1_RS; src2 = SRC2_ZIMM;
               rs_used = 1'b1; rf_we = 1'b1; rf_waddr = rt;
            end
            OP_LUI: begin
               alu_op[ALU_LUI] = 1'b1; src2 = SRC2_ZIMM;
               rf_we = 1'b1; rf_waddr = rt;
            end
            OP_LW: begin
               alu_op[ALU_ADD] = 1'b1; src1 = SRC1_RS; src2 = SRC2_SIMM;
               rs_used = 1'b1; ram_en = 1'b1; sel_rf_res = 1'b1;
               rf_we = 1'b1; rf_waddr = rt;
            end
            OP_SW: begin
               alu_op[ALU_ADD] = 1'b1; src1 = SRC1_RS; src2 = SRC2_SIMM;
               rs_used = 1'b1; rt_used = 1'b1;
               ram_en = 1'b1; ram_wen = 4'b1111;
            end
            OP_BEQ: begin
               rs_used = 1'b1; rt_used = 1'b1;
               br_take = (rdata1 == rdata2); br_tgt = br_rel;
            end
            OP_BNE: begin
               rs_used = 1'b1; rt_used = 1'b1;
               br_take = (rdata1 != rdata2); br_tgt = br_rel;
            end
            OP_J: begin
               br_take = 1'b1; br_tgt = j_abs;
            end
            OP_JAL: begin
               br_take = 1'b1; br_tgt = j_abs;
               alu_op[ALU_ADD] = 1'b1; src1 = SRC1_PC; src2 = SRC2_C8;
               rf_we = 1'b1; rf_waddr = 5'd31;
            end
`ifdef ID_BRANCH_EXT_EN
            OP_REGIMM: begin
               if (rt == RT_BLTZ || rt == RT_BGEZ || rt == RT_BLTZAL || rt == RT_BGEZAL) begin
                  // rt[0] selects >=0 vs <0, rt[4] selects the link form
                  rs_used = 1'b1; br_tgt = br_rel;
                  br_take = rt[0] ? ~rdata1[31] : rdata1[31];
                  if (rt[4]) begin
                     alu_op[ALU_ADD] = 1'b1; src1 = SRC1_PC; src2 = SRC2_C8;
                     rf_we = 1'b1; rf_waddr = 5'd31;
                  end
               end
            end
            OP_BLEZ: begin
               rs_used = 1'b1; br_tgt = br_rel;
               br_take = rdata1[31] || (rdata1 == 32'd0);
            end
            OP_BGTZ: begin
               rs_used = 1'b1; br_tgt = br_rel;
               br_take = !rdata1[31] && (rdata1 != 32'd0);
            end
`endif
            default: ;
         endcase
      end
   end

   logic ld_hit;
   assign ld_hit = fwd[0].is_load && fwd[0].we && fwd[0].waddr != 5'd0 &&
                   ((rs_used && fwd[0].waddr == rs) || (rt_used && fwd[0].waddr == rt));
   assign stallreq = id_ce && ld_hit;

   // A branch resolved on stale load data must not redirect IF.
   logic br_e;
   assign br_e   = br_take && !stallreq;
   assign br_bus = {br_e, br_e ? br_tgt : 32'd0};

   assign id_to_ex_bus = {id_pc, inst_d, alu_op, src1, src2, ram_en, ram_wen,
                          rf_we, rf_waddr, sel_rf_res, rdata1, rdata2};

   logic unused_sig;
   assign unused_sig = ^{fwd_bus, stall[5:3], stall[0], hold_v};

endmodule
